// File: rtl/cache_mem_responder_if.sv
// Cache-to-memory request/response bundle.
// The slave side is the backing-memory responder.
interface cache_mem_responder_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  logic                     req_valid_i;
  logic                     req_ready_o;
  logic                     req_we_i;
  logic [ADDRESS_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0]    req_wdata_i;
  logic                     rsp_valid_o;
  logic                     rsp_ready_i;
  logic                     rsp_we_o;
  logic [DATA_WIDTH-1:0]    rsp_rdata_o;
  logic                     rsp_err_o;

  modport master (
    output req_valid_i,
    output req_we_i,
    output req_addr_i,
    output req_wdata_i,
    output rsp_ready_i,
    input  req_ready_o,
    input  rsp_valid_o,
    input  rsp_we_o,
    input  rsp_rdata_o,
    input  rsp_err_o
  );

  modport slave (
    input  req_valid_i,
    input  req_we_i,
    input  req_addr_i,
    input  req_wdata_i,
    input  rsp_ready_i,
    output req_ready_o,
    output rsp_valid_o,
    output rsp_we_o,
    output rsp_rdata_o,
    output rsp_err_o
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Fixed-latency backing memory for cache fills and writebacks.
// Optional MEM_ALIGN_CHECK_EN flags misaligned requests with rsp_err_o.
module cache_mem_responder #(
  parameter int ADDRESS_WIDTH   = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_DEPTH_WIDTH = 8,
  parameter int LATENCY         = 4
) (
  input logic clk_i,
  input logic rst_ni,
  cache_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  localparam logic [3:0] LoadVal = 4'(LATENCY - 1);

  state_e                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       we_q, we_d;
  logic                       bad_q, bad_d;
  logic [MEM_DEPTH_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic                       rsp_we_q, rsp_we_d;
  logic                       rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic                       mem_we;
  logic                       misaligned;

  logic [DATA_WIDTH-1:0] mem_q [2**MEM_DEPTH_WIDTH];

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |bus.req_addr_i[1:0];
  logic unused_addr;
  assign unused_addr =
    ^bus.req_addr_i[ADDRESS_WIDTH-1:MEM_DEPTH_WIDTH+2];
`else
  assign misaligned = 1'b0;
  logic unused_addr;
  assign unused_addr =
    ^{bus.req_addr_i[ADDRESS_WIDTH-1:MEM_DEPTH_WIDTH+2],
      bus.req_addr_i[1:0]};
`endif

  assign bus.req_ready_o = (state_q == IDLE) && rst_ni;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_we_o    = rsp_we_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    bad_d       = bad_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          state_d = BUSY;
          cnt_d   = LoadVal;
          we_d    = bus.req_we_i;
          bad_d   = misaligned;
          idx_d   = bus.req_addr_i[MEM_DEPTH_WIDTH+1:2];
          wdata_d = bus.req_wdata_i;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_we_d    = we_q;
          rsp_err_d   = bad_q;
          mem_we      = we_q && !bad_q;
          // Writes and misaligned accesses answer with zero data
          rsp_rdata_d = (we_q || bad_q) ? '0 : mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      bad_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      bad_q       <= bad_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end
endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
Backing-memory responder for the cache subsystem. It is the memory end of the cache-to-memory interface: it accepts one line-fill read or dirty-writeback write per handshake and answers after a fixed programmable latency. Caches (direct-mapped now, set-associative later) connect to it in place of a zero-latency data memory. One request outstanding at a time.

Parameters:
ADDRESS_WIDTH, 16, byte address width of the request port
DATA_WIDTH, 32, word width; one word per request
MEM_DEPTH_WIDTH, 8, log2 of storage depth in words (256 words)
LATENCY, 4, cycles from request accept edge to rsp_valid_o high; legal range 1..15

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_ni  in  1  reset, asynchronous, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  responder can accept a request
req_we_i  in  1  1 = write (writeback), 0 = read (fill)
req_addr_i  in  ADDRESS_WIDTH  byte address
req_wdata_i  in  DATA_WIDTH  write data
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  requester accepts the response
rsp_we_o  out  1  echo of the captured req_we_i
rsp_rdata_o  out  DATA_WIDTH  read data; 0 for write responses
rsp_err_o  out  1  error flag; see Optional Feature

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE, latency counter 0, req_ready_o 0 while rst_ni is low, rsp_valid_o 0, rsp_we_o 0, rsp_rdata_o 0, rsp_err_o 0. Storage contents are not reset and are zero at power-up.
- Word index = req_addr_i[MEM_DEPTH_WIDTH+1:2]. Address bits above the index alias. Bits [1:0] are ignored unless the Optional Feature is enabled.
- FSM states:
  - IDLE: req_ready_o = 1 (rst_ni high). On an edge with req_valid_i && req_ready_o, capture we, word index and wdata into holding registers, load counter = LATENCY-1, then go to BUSY.
  - BUSY: req_ready_o = 0. Counter decrements each edge. On the edge where the counter equals 0:
    - Write: commit wdata to storage.
    - Read: register storage[index] into rsp_rdata_o.
    - Set rsp_valid_o, then go to RESP.
    - With LATENCY = 1, rsp_valid_o is high in the cycle directly after the accept edge.
  - RESP: rsp_valid_o = 1, and rsp_we_o, rsp_rdata_o and rsp_err_o are held stable until rsp_ready_i is sampled high. On that edge, clear rsp_valid_o and rsp_rdata_o, then go to IDLE.
- Throughput: a new request is not accepted in the same cycle a response completes. Minimum request spacing is LATENCY+2 cycles when rsp_ready_i is tied high.
- req_valid_i asserted during BUSY or RESP is ignored (not captured). The requester holds it until it sees req_ready_o.
- Read-after-write to the same index returns the new data, because the write commits before the read's response.
- Write response: rsp_rdata_o = 0, rsp_we_o = 1.
- Reset mid-operation (BUSY): the captured request is discarded, no storage write occurs, and no response is issued. Reset in RESP: the response is dropped.
- rsp_ready_i high while rsp_valid_o is low has no effect.

Optional Feature:
Macro MEM_ALIGN_CHECK_EN.
- Defined: a request with req_addr_i[1:0] != 0 is still accepted and timed normally. No storage write occurs, read data is 0, and rsp_err_o = 1 with the response. Aligned requests give rsp_err_o = 0.
- Undefined: bits [1:0] are ignored, the access proceeds at the word index, and rsp_err_o is tied to 0.

Test Plan:
- Reset, then LATENCY=4: write addr 0x0010 data 0xDEADBEEF, accepted at edge T -> rsp_valid_o high at T+4, rsp_we_o=1, rsp_rdata_o=0; after rsp_ready_i, req_ready_o high again.
- Read addr 0x0010 after that write -> rsp_rdata_o=0xDEADBEEF, rsp_we_o=0, exactly 4 cycles after accept.
- Aliasing: write 0x0404 data 0x12345678, then read 0x0004 (MEM_DEPTH_WIDTH=8) -> 0x12345678.
- Backpressure: read response with rsp_ready_i low for 3 cycles -> rsp_valid_o and rsp_rdata_o stable all 3 cycles; second req_valid_i during this time is not accepted (req_ready_o=0).
- Reset pulse during BUSY of write 0x0020 data 0xAAAA5555 -> no response; a later read of 0x0020 returns 0x00000000.
- MEM_ALIGN_CHECK_EN defined: write 0x0021 data 0x1 -> rsp_err_o=1; read 0x0020 -> 0x00000000, rsp_err_o=0. Macro undefined: the same write stores 0x1 at index 8 and rsp_err_o=0.
